// File: rtl/branch_sequencer.sv
// ---------------------------------------------------------------------------
// branch_sequencer
//
// Multi-cycle instruction sequencer for the RISC core. Owns the program
// counter, the return-address register and the latched ALU condition flags.
// Fetches one instruction at a time, hands non-branch instructions to the ALU
// and resolves branch / call / return opcodes into the next PC.
//
// Ports
//   clk, rst        rising-edge clock, synchronous active-high reset
//   run             level: leave IDLE and keep fetching while high
//   imem_req/addr   fetch request (addr = pc), held until imem_ack
//   imem_ack/data   one-cycle fetch completion with the instruction word
//   instr           latched instruction word for the decoder
//   opcode          decoded opcode (valid from DECODE onward)
//   is_branch       decoded instruction is a branch / call / ret
//   offset_L        signed 25-bit branch offset
//   reg_value       rs read value used by "br rs"
//   alu_start       one-cycle ALU start pulse
//   alu_done        ALU result and flags valid
//   zflag, carryflag, signflag, overflowflag   ALU flags, sampled on alu_done
//   pc, ra          program counter, return-address register
//   flags           latched {v,s,c,z}
//   retire          one-cycle pulse per completed instruction
//   halted          sticky error halt after an ALU timeout
//   state_dbg       current FSM state
//
// Handshakes: imem_req is a request level that stays high in FETCH until the
// cycle in which imem_ack is seen; instr is captured on that same edge and
// the request drops with it. alu_start is a single-cycle pulse issued in
// DECODE; the sequencer then waits in EXEC for alu_done, which is only
// honoured while in EXEC. Acks arriving in any other state are ignored.
// ---------------------------------------------------------------------------
module branch_sequencer #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          ALU_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    output logic [31:0] instr,
    input  logic [6:0]  opcode,
    input  logic        is_branch,
    input  logic [24:0] offset_L,
    input  logic [31:0] reg_value,
    output logic        alu_start,
    input  logic        alu_done,
    input  logic        zflag,
    input  logic        carryflag,
    input  logic        signflag,
    input  logic        overflowflag,
    output logic [31:0] pc,
    output logic [31:0] ra,
    output logic [3:0]  flags,
    output logic        retire,
    output logic        halted,
    output logic [2:0]  state_dbg
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_UPDATE = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    localparam logic [6:0] OP_B    = 7'b1000000;
    localparam logic [6:0] OP_BR   = 7'b1000001;
    localparam logic [6:0] OP_BZ   = 7'b1000010;
    localparam logic [6:0] OP_BNZ  = 7'b1000011;
    localparam logic [6:0] OP_BCY  = 7'b1000100;
    localparam logic [6:0] OP_BNCY = 7'b1000101;
    localparam logic [6:0] OP_BS   = 7'b1000110;
    localparam logic [6:0] OP_BNS  = 7'b1000111;
    localparam logic [6:0] OP_BV   = 7'b1001000;
    localparam logic [6:0] OP_BNV  = 7'b1001001;
    localparam logic [6:0] OP_CALL = 7'b1001010;
    localparam logic [6:0] OP_RET  = 7'b1001011;

    localparam int CW = $clog2(ALU_TIMEOUT + 1);

    logic [2:0]    state;
    logic [CW-1:0] exec_cnt;
    logic          br_q;       // instruction in flight is a branch-class op
    logic [31:0]   seq_pc;
    logic [31:0]   tgt_pc;
    logic [31:0]   next_pc;
    logic          is_call;

    // flags register layout is {v,s,c,z}
    logic f_z, f_c, f_s, f_v;
    assign f_z = flags[0];
    assign f_c = flags[1];
    assign f_s = flags[2];
    assign f_v = flags[3];

    assign seq_pc = pc + 32'd1;
    assign tgt_pc = seq_pc + {{7{offset_L[24]}}, offset_L};
    assign is_call = br_q && (opcode == OP_CALL);

    // Next-PC selection. Conditions come from the latched flags only, so a
    // branch sees the flags of the last completed ALU op, not live inputs.
    always_comb begin
        next_pc = seq_pc;
        if (br_q) begin
            case (opcode)
                OP_B:    next_pc = tgt_pc;
                OP_BR:   next_pc = reg_value;
                OP_BZ:   next_pc = f_z  ? tgt_pc : seq_pc;
                OP_BNZ:  next_pc = !f_z ? tgt_pc : seq_pc;
                OP_BCY:  next_pc = f_c  ? tgt_pc : seq_pc;
                OP_BNCY: next_pc = !f_c ? tgt_pc : seq_pc;
                OP_BS:   next_pc = f_s  ? tgt_pc : seq_pc;
                OP_BNS:  next_pc = !f_s ? tgt_pc : seq_pc;
                OP_BV:   next_pc = f_v  ? tgt_pc : seq_pc;
                OP_BNV:  next_pc = !f_v ? tgt_pc : seq_pc;
                OP_CALL: next_pc = tgt_pc;
                OP_RET:  next_pc = ra;
                default: next_pc = seq_pc;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            pc       <= RESET_PC;
            ra       <= 32'd0;
            flags    <= 4'd0;
            instr    <= 32'd0;
            exec_cnt <= '0;
            br_q     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (run) state <= S_FETCH;
                end
                S_FETCH: begin
                    if (imem_ack) begin
                        instr <= imem_data;
                        state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    br_q     <= is_branch;
                    // first EXEC cycle is counted as cycle 1
                    exec_cnt <= CW'(1);
                    state    <= is_branch ? S_UPDATE : S_EXEC;
                end
                S_EXEC: begin
                    if (alu_done) begin
                        flags <= {overflowflag, signflag, carryflag, zflag};
                        state <= S_UPDATE;
                    end else if (exec_cnt == CW'(ALU_TIMEOUT)) begin
                        state <= S_HALT;
                    end else begin
                        exec_cnt <= exec_cnt + CW'(1);
                    end
                end
                S_UPDATE: begin
                    pc <= next_pc;
                    if (is_call) ra <= seq_pc;
                    state <= run ? S_FETCH : S_IDLE;
                end
                S_HALT: begin
                    state <= S_HALT;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Outputs are decoded from the state register, so they reset with it.
    assign imem_req  = (state == S_FETCH);
    assign imem_addr = pc;
    assign alu_start = (state == S_DECODE) && !is_branch;
    assign retire    = (state == S_UPDATE);
    assign halted    = (state == S_HALT);
    assign state_dbg = state;

endmodule

// File: tb/tb_branch_sequencer.sv
// ---------------------------------------------------------------------------
// tb_branch_sequencer
//
// Drives branch_sequencer with a small program. The bench plays the roles of
// instruction memory, decoder and ALU. Instruction words are encoded as
// {opcode[6:0], L[24:0]}; is_branch is opcode bit 6. A reference model tracks
// pc/ra/flags and pushes the expected post-instruction state into exp_q when
// the fetch is acknowledged; the monitor pops and compares on every retire.
// ---------------------------------------------------------------------------
module tb_branch_sequencer;

    localparam logic [31:0] RESET_PC    = 32'h0000_0000;
    localparam int          ALU_TIMEOUT = 16;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_HALT = 3'd5;

    localparam logic [6:0] ALU   = 7'h01;
    localparam logic [6:0] B     = 7'b1000000;
    localparam logic [6:0] BR    = 7'b1000001;
    localparam logic [6:0] BZ    = 7'b1000010;
    localparam logic [6:0] BNZ   = 7'b1000011;
    localparam logic [6:0] BCY   = 7'b1000100;
    localparam logic [6:0] BNCY  = 7'b1000101;
    localparam logic [6:0] BS    = 7'b1000110;
    localparam logic [6:0] BNS   = 7'b1000111;
    localparam logic [6:0] BV    = 7'b1001000;
    localparam logic [6:0] BNV   = 7'b1001001;
    localparam logic [6:0] CALL  = 7'b1001010;
    localparam logic [6:0] RET   = 7'b1001011;
    localparam logic [6:0] BUNK  = 7'b1001100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_data = 32'd0;
    logic [31:0] instr;
    logic [6:0]  opcode;
    logic        is_branch;
    logic [24:0] offset_L;
    logic [31:0] reg_value = 32'd0;
    logic        alu_start;
    logic        alu_done = 1'b0;
    logic        zflag = 1'b0, carryflag = 1'b0, signflag = 1'b0, overflowflag = 1'b0;
    logic [31:0] pc, ra;
    logic [3:0]  flags;
    logic        retire, halted;
    logic [2:0]  state_dbg;

    // decoder stand-in
    assign opcode    = instr[31:25];
    assign offset_L  = instr[24:0];
    assign is_branch = instr[31];

    branch_sequencer #(.RESET_PC(RESET_PC), .ALU_TIMEOUT(ALU_TIMEOUT)) dut (
        .clk(clk), .rst(rst), .run(run),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_data(imem_data),
        .instr(instr), .opcode(opcode), .is_branch(is_branch),
        .offset_L(offset_L), .reg_value(reg_value),
        .alu_start(alu_start), .alu_done(alu_done),
        .zflag(zflag), .carryflag(carryflag), .signflag(signflag),
        .overflowflag(overflowflag),
        .pc(pc), .ra(ra), .flags(flags), .retire(retire), .halted(halted),
        .state_dbg(state_dbg)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // scoreboard state
    int n_tests = 0;
    int n_fail  = 0;
    logic [67:0] exp_q[$];          // {pc, ra, flags} after each retire
    logic [31:0] m_pc, m_ra;
    logic [3:0]  m_flags;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // monitor: compare architectural state after each retire
    initial begin
        logic [67:0] e;
        forever begin
            @(negedge clk);
            if (retire === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_retire", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    @(posedge clk);
                    #1;
                    check("retire_pc", pc, e[67:36]);
                    check("retire_ra", ra, e[35:4]);
                    check("retire_flags", {28'd0, flags}, {28'd0, e[3:0]});
                end
            end
        end
    end

    // driver tasks (all called at a negedge)
    task automatic wait_req();
        int n = 0;
        while (imem_req !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("req_timeout", 32'd0, 32'd1);
    endtask

    task automatic model_step(input logic [6:0] op, input logic [24:0] l,
                              input logic [3:0] f, input logic [31:0] rv);
        logic [31:0] seq, tgt;
        seq = m_pc + 32'd1;
        tgt = seq + {{7{l[24]}}, l};
        if (!op[6]) begin
            m_pc    = seq;
            m_flags = f;
        end else begin
            case (op)
                B:    m_pc = tgt;
                BR:   m_pc = rv;
                BZ:   m_pc = (m_flags[0] == 1'b1) ? tgt : seq;
                BNZ:  m_pc = (m_flags[0] == 1'b0) ? tgt : seq;
                BCY:  m_pc = (m_flags[1] == 1'b1) ? tgt : seq;
                BNCY: m_pc = (m_flags[1] == 1'b0) ? tgt : seq;
                BS:   m_pc = (m_flags[2] == 1'b1) ? tgt : seq;
                BNS:  m_pc = (m_flags[2] == 1'b0) ? tgt : seq;
                BV:   m_pc = (m_flags[3] == 1'b1) ? tgt : seq;
                BNV:  m_pc = (m_flags[3] == 1'b0) ? tgt : seq;
                CALL: begin m_ra = seq; m_pc = tgt; end
                RET:  m_pc = m_ra;
                default: m_pc = seq;
            endcase
        end
        exp_q.push_back({m_pc, m_ra, m_flags});
    endtask

    task automatic do_instr(input logic [6:0] op, input logic [24:0] l, input logic [3:0] f,
                            input int alu_lat, input logic [31:0] rv, input bit drop_run);
        wait_req();
        check("fetch_addr", imem_addr, m_pc);
        @(negedge clk);                    // ack one cycle after the request
        imem_ack  = 1'b1;
        imem_data = {op, l};
        reg_value = rv;
        if (drop_run) run = 1'b0;
        model_step(op, l, f, rv);
        @(negedge clk);                    // now in DECODE
        imem_ack  = 1'b0;
        imem_data = $urandom;
        {overflowflag, signflag, carryflag, zflag} = 4'($urandom_range(0, 15));
        if (!op[6]) begin
            check("alu_start", {31'd0, alu_start}, 32'd1);
            repeat (alu_lat) @(negedge clk);
            alu_done = 1'b1;
            {overflowflag, signflag, carryflag, zflag} = f;
            @(negedge clk);
            alu_done = 1'b0;
            {overflowflag, signflag, carryflag, zflag} = 4'($urandom_range(0, 15));
        end else begin
            check("alu_start_br", {31'd0, alu_start}, 32'd0);
        end
    endtask

    task automatic model_reset();
        m_pc    = RESET_PC;
        m_ra    = 32'd0;
        m_flags = 4'd0;
    endtask

    // main sequence
    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_pc", pc, RESET_PC);
        check("rst_ra", ra, 32'd0);
        check("rst_flags", {28'd0, flags}, 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_alu_start", {31'd0, alu_start}, 32'd0);
        check("rst_retire", {31'd0, retire}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_state", {29'd0, state_dbg}, {29'd0, S_IDLE});
        rst = 1'b0;
        run = 1'b1;

        // three ALU ops, alu_done after 2 cycles
        do_instr(ALU, 25'd0, 4'b0000, 2, 32'd0, 1'b0);
        do_instr(ALU, 25'd0, 4'b0000, 2, 32'd0, 1'b0);
        do_instr(ALU, 25'd0, 4'b0000, 2, 32'd0, 1'b0);
        // b +0 -> pc 4; ALU sets z; bz -2 at pc 5 -> 4
        do_instr(B,   25'd0,         4'b0000, 0, 32'd0, 1'b0);
        do_instr(ALU, 25'd0,         4'b0001, 1, 32'd0, 1'b0);
        do_instr(BZ,  25'h1FF_FFFE,  4'b0000, 0, 32'd0, 1'b0);
        // z clear -> bz not taken -> 6
        do_instr(ALU, 25'd0,         4'b0000, 1, 32'd0, 1'b0);
        do_instr(BZ,  25'h1FF_FFFE,  4'b0000, 0, 32'd0, 1'b0);
        // to 0x10, call +0x20, ret
        do_instr(B,    25'd9,    4'b0000, 0, 32'd0, 1'b0);
        do_instr(CALL, 25'h20,   4'b0000, 0, 32'd0, 1'b0);
        do_instr(RET,  25'd0,    4'b0000, 0, 32'd0, 1'b0);
        // flags {v,s,c,z}=1010, then every conditional type
        do_instr(ALU,  25'd0,         4'b1010, 3, 32'd0, 1'b0);
        do_instr(BZ,   25'd7,         4'b0000, 0, 32'd0, 1'b0);
        do_instr(BNZ,  25'd2,         4'b0000, 0, 32'd0, 1'b0);
        do_instr(BCY,  25'd1,         4'b0000, 0, 32'd0, 1'b0);
        do_instr(BNCY, 25'd7,         4'b0000, 0, 32'd0, 1'b0);
        do_instr(BS,   25'd7,         4'b0000, 0, 32'd0, 1'b0);
        do_instr(BNS,  25'd3,         4'b0000, 0, 32'd0, 1'b0);
        do_instr(BV,   25'h1FF_FFFF,  4'b0000, 0, 32'd0, 1'b0);
        do_instr(BNV,  25'd7,         4'b0000, 0, 32'd0, 1'b0);
        do_instr(BUNK, 25'd5,         4'b0000, 0, 32'd0, 1'b0);
        do_instr(BR,   25'd0,         4'b0000, 0, 32'h0000_0400, 1'b0);
        check("br_rs_target", m_pc, 32'h0000_0400);

        // run dropped mid-instruction: completes, then parks in IDLE
        do_instr(ALU, 25'd0, 4'b0100, 1, 32'd0, 1'b1);
        repeat (3) @(negedge clk);
        check("idle_req", {31'd0, imem_req}, 32'd0);
        check("idle_state", {29'd0, state_dbg}, {29'd0, S_IDLE});
        run = 1'b1;

        // PC wrap-around
        do_instr(BR,  25'd0, 4'b0000, 0, 32'hFFFF_FFFF, 1'b0);
        do_instr(ALU, 25'd0, 4'b0011, 1, 32'd0, 1'b0);

        // ALU timeout
        wait_req();
        check("to_fetch_addr", imem_addr, 32'd0);
        @(negedge clk);
        imem_ack  = 1'b1;
        imem_data = {ALU, 25'd0};
        @(negedge clk);
        imem_ack  = 1'b0;
        check("to_alu_start", {31'd0, alu_start}, 32'd1);
        repeat (ALU_TIMEOUT) @(negedge clk);
        check("to_not_yet_halted", {31'd0, halted}, 32'd0);
        @(negedge clk);
        check("to_halted", {31'd0, halted}, 32'd1);
        check("to_state", {29'd0, state_dbg}, {29'd0, S_HALT});
        for (int i = 0; i < 6; i++) begin
            imem_ack  = 1'($urandom_range(0, 1));
            imem_data = $urandom;
            alu_done  = 1'($urandom_range(0, 1));
            run       = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("halt_req", {31'd0, imem_req}, 32'd0);
            check("halt_sticky", {31'd0, halted}, 32'd1);
            check("halt_pc", pc, 32'd0);
        end
        imem_ack = 1'b0;
        alu_done = 1'b0;
        run      = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        model_reset();
        check("halt_rst_pc", pc, RESET_PC);
        check("halt_rst_halted", {31'd0, halted}, 32'd0);
        check("halt_rst_flags", {28'd0, flags}, 32'd0);
        rst = 1'b0;

        // reset while fetching, with an ack in the same cycle
        run = 1'b1;
        @(negedge clk);
        wait_req();
        rst       = 1'b1;
        imem_ack  = 1'b1;
        imem_data = 32'hDEAD_BEEF;
        @(negedge clk);
        check("fetch_rst_state", {29'd0, state_dbg}, {29'd0, S_IDLE});
        check("fetch_rst_req", {31'd0, imem_req}, 32'd0);
        check("fetch_rst_instr", instr, 32'd0);
        check("fetch_rst_retire", {31'd0, retire}, 32'd0);
        rst      = 1'b0;
        imem_ack = 1'b0;
        run      = 1'b0;
        repeat (4) @(negedge clk);
        check("fetch_rst_no_retire", {31'd0, retire}, 32'd0);

        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_sequencer.md
Name: branch_sequencer

Overview:
- Multi-cycle instruction sequencer for the RISC core.
- Owns the program counter (PC), the return-address register (ra) and the latched condition flags.
- Drives the instruction-fetch handshake and starts the ALU for non-branch instructions.
- Resolves all branch, call and return opcodes to produce the next PC; it is the sequencing controller in front of the datapath.

Parameters:
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- ALU_TIMEOUT, 16: max EXEC cycles waiting for alu_done before the sequencer halts with an error.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- run  in  1  level; sequencer leaves IDLE and keeps fetching while high
- imem_req  out  1  fetch request, held until imem_ack
- imem_addr  out  32  fetch address (= pc)
- imem_ack  in  1  one-cycle fetch completion
- imem_data  in  32  instruction word, valid with imem_ack
- instr  out  32  latched instruction to the decoder
- opcode  in  7  decoded opcode, valid in DECODE onward
- is_branch  in  1  decoded instruction is a branch/call/ret
- offset_L  in  25  signed branch offset from the decoder
- reg_value  in  32  rs read value (used by br rs)
- alu_start  out  1  one-cycle ALU start pulse
- alu_done  in  1  ALU result/flags valid
- zflag, carryflag, signflag, overflowflag  in  1 each  ALU flags, sampled with alu_done
- pc  out  32  current PC
- ra  out  32  return-address register
- flags  out  4  latched {v,s,c,z}
- retire  out  1  one-cycle pulse per completed instruction
- halted  out  1  sticky error halt (ALU timeout)

Behaviour:
- Reset values: pc=RESET_PC, ra=0, flags=0, instr=0, imem_req=0, alu_start=0, retire=0, halted=0, state=IDLE. rst in any state aborts the operation in progress; pending imem_ack/alu_done are ignored from that point.
- States: IDLE, FETCH, DECODE, EXEC, UPDATE, HALT.
- IDLE: when run=1, go to FETCH next cycle.
- FETCH: imem_req=1, imem_addr=pc. On imem_ack, latch instr<=imem_data, drop imem_req that same edge, go to DECODE.
- DECODE: one cycle.
  - If is_branch=1, go to UPDATE.
  - Otherwise pulse alu_start for exactly one cycle and go to EXEC.
- EXEC: wait for alu_done.
  - On alu_done, latch flags<={overflowflag,signflag,carryflag,zflag} and go to UPDATE.
  - If ALU_TIMEOUT cycles elapse with no alu_done, go to HALT and set halted=1. The cycle counter starts at 1 in the first EXEC cycle.
- UPDATE: one cycle; load the next PC, pulse retire, then go to FETCH if run=1, else IDLE.
- HALT: absorbing state; only rst leaves it.
- Next-PC rules, with seq=pc+1 (word addressed) and sext(L)={{7{L[24]}},L}, 32-bit wrap-around addition:
  - Non-branch: pc<=seq.
  - 1000000 b L: pc<=seq+sext(L).
  - 1000001 br rs: pc<=reg_value (absolute).
  - 1000010 bz / 1000011 bnz: taken if z==1 / z==0.
  - 1000100 bcy / 1000101 bncy: taken on c.
  - 1000110 bs / 1000111 bns: taken on s.
  - 1001000 bv / 1001001 bnv: taken on v.
  - Taken conditional: pc<=seq+sext(L). Not taken: pc<=seq.
  - 1001010 call: ra<=seq, pc<=seq+sext(L).
  - 1001011 ret: pc<=ra.
  - Any other opcode with is_branch=1: treated as not taken, pc<=seq.
- Conditional branches use the latched flags register, never the live flag inputs.
- Branches do not modify flags.
- Returning a PC of 0xFFFF_FFFF+1 wraps to 0; no trap is raised.
- run dropping mid-instruction does not abort: the current instruction completes through UPDATE, then the sequencer parks in IDLE.
- Minimum latency: branch = 4 cycles (FETCH with same-cycle ack, DECODE, UPDATE, next FETCH); ALU op = 5 with alu_done on the first EXEC cycle.

Test Plan:
- Reset then run=1, imem_ack returned one cycle after each req, 3 ALU ops with alu_done after 2 cycles -> imem_addr 0,1,2; three retire pulses; pc=3.
- ALU op sets z=1 via alu_done, then bz with L=25'h1FFFFFE (-2) at pc=5 -> pc=4. Repeat with z=0 -> pc=6.
- call at pc=0x10 with L=0x20 -> ra=0x11, pc=0x31. Subsequent ret -> pc=0x11.
- br rs with reg_value=0x0000_0400 -> pc=0x400. Flags unchanged across all branch types.
- alu_done never asserted -> halted=1 exactly ALU_TIMEOUT cycles after EXEC entry. Further imem_ack/run are ignored. rst -> pc=RESET_PC, halted=0.
- rst asserted in FETCH with imem_req=1 and imem_ack arriving the same cycle -> next cycle: IDLE, imem_req=0, instr=0, no retire.
